// File: rtl/aes128_round_ctrl.sv
// aes128_round_ctrl
// Iterative AES-128 encryption sequencer. Owns the state register, the
// round-key register, the round counter and the Rcon generator, and drives
// an external single-round combinational datapath (SB -> SR -> MC? -> ARK
// plus one key-expansion step). One round is executed per clock.
//
// Optional build macro: AES_CTRL_ABORT_EN
//   When defined, adds a synchronous 'abort' input that returns the block
//   to IDLE and clears all key/state material from ROUND or DONE.
//   When undefined, the port and all abort logic are absent.

module aes128_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct,
    output logic         busy,
    output logic [3:0]   round_cnt,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    output logic [7:0]   dp_rcon,
    output logic         dp_final,
    input  logic [127:0] dp_round_out,
    input  logic [127:0] dp_key_next
`ifdef AES_CTRL_ABORT_EN
    ,
    input  logic         abort
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         ov_q, ov_d;
    logic         accept;

    // Multiply by x in GF(2^8) modulo the AES polynomial: the Rcon step.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Handshake and status: in_ready is forced low during reset so no job
    // can be launched while the registers are being cleared.
    always_comb begin
        in_ready  = (fsm_q == IDLE) && !rst;
        accept    = in_valid && in_ready;
        busy      = (fsm_q == ROUND) || (fsm_q == DONE);
        out_valid = ov_q;
        ct        = state_q;
        round_cnt = rnd_q;
        dp_state  = state_q;
        dp_key    = key_q;
        dp_rcon   = rcon_q;
        dp_final  = (fsm_q == ROUND) && (rnd_q == LAST_ROUND);
    end

    // Next-state and register update logic; every register holds by default.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        rcon_d  = rcon_q;
        ov_d    = ov_q;

        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    // Initial AddRoundKey is folded into the load.
                    state_d = pt ^ key;
                    key_d   = key;
                    rnd_d   = 4'd1;
                    rcon_d  = 8'h01;
                    fsm_d   = ROUND;
                end
            end

            ROUND: begin
                state_d = dp_round_out;
                key_d   = dp_key_next;
                rcon_d  = xtime(rcon_q);
                if (rnd_q == LAST_ROUND) begin
                    // Counter stays at the last round while the result waits.
                    fsm_d = DONE;
                    ov_d  = 1'b1;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    ov_d  = 1'b0;
                    rnd_d = 4'd0;
                    fsm_d = IDLE;
                end
            end

            default: begin
                fsm_d = IDLE;
                ov_d  = 1'b0;
                rnd_d = 4'd0;
            end
        endcase

`ifdef AES_CTRL_ABORT_EN
        // Abort overrides everything outside IDLE, including a pending output
        // handshake, and scrubs key material. In IDLE it is a no-op so an
        // accept in the same cycle still goes through.
        if (abort && (fsm_q != IDLE)) begin
            fsm_d   = IDLE;
            state_d = '0;
            key_d   = '0;
            rnd_d   = 4'd0;
            rcon_d  = 8'h01;
            ov_d    = 1'b0;
        end
`endif
    end

    // Register bank with asynchronous clear; a reset mid-job drops the job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= 4'd0;
            rcon_q  <= 8'h01;
            ov_q    <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            rcon_q  <= rcon_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// tb_aes128_round_ctrl
// Directed bench for aes128_round_ctrl. The bench supplies a behavioural
// AES round/key-expansion datapath; ciphertexts are checked against the
// published FIPS-197 vectors. Abort tests are built when AES_CTRL_ABORT_EN
// is defined.

module tb_aes128_round_ctrl;

    localparam int NUM_ROUNDS = 10;

    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct;
    logic         busy;
    logic [3:0]   round_cnt;
    logic [127:0] dp_state;
    logic [127:0] dp_key;
    logic [7:0]   dp_rcon;
    logic         dp_final;
    logic [127:0] dp_round_out;
    logic [127:0] dp_key_next;
`ifdef AES_CTRL_ABORT_EN
    logic         abort;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    aes128_round_ctrl #(.NUM_ROUNDS(NUM_ROUNDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pt           (pt),
        .key          (key),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ct           (ct),
        .busy         (busy),
        .round_cnt    (round_cnt),
        .dp_state     (dp_state),
        .dp_key       (dp_key),
        .dp_rcon      (dp_rcon),
        .dp_final     (dp_final),
        .dp_round_out (dp_round_out),
        .dp_key_next  (dp_key_next)
`ifdef AES_CTRL_ABORT_EN
        ,
        .abort        (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural AES datapath ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15-n -: 8];
    endfunction

    // S-box from first principles: a^254 (multiplicative inverse) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3, rw, t, w4, w5, w6, w7;
        w3 = k[31:0];
        rw = {w3[23:0], w3[31:24]};
        t  = {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
        t  = t ^ {rc, 24'h0};
        w4 = k[127:96] ^ t;
        w5 = k[95:64] ^ w4;
        w6 = k[63:32] ^ w5;
        w7 = w3 ^ w6;
        return {w4, w5, w6, w7};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] rk,
                                               input logic fin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = b[4*((c+r)%4)+r];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ rk;
    endfunction

    always_comb begin
        dp_key_next  = key_exp(dp_key, dp_rcon);
        dp_round_out = aes_round(dp_state, dp_key_next, dp_final);
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a job at the next falling edge; returns 1ns after the accept edge.
    task automatic start_job(input logic [127:0] p, input logic [127:0] k, input logic hold);
        @(negedge clk);
        in_valid = 1'b1;
        pt       = p;
        key      = k;
        tick();
        if (!hold) in_valid = 1'b0;
    endtask

    // Counts edges from just after the accept edge until out_valid appears.
    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk(tag, 128'(lat), 128'(NUM_ROUNDS));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        int ov_seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pt        = '0;
        key       = '0;
`ifdef AES_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        // ---- reset state ----
        #3;
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_round_cnt", round_cnt, 0);
        chk("rst_rcon",      dp_rcon,   8'h01);
        chk("rst_state",     dp_state,  0);
        chk("rst_key",       dp_key,    0);
        chk("rst_final",     dp_final,  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);

        // ---- FIPS-197 vector, Rcon / final sequence, latency ----
        start_job(PT_A, KEY_A, 1'b0);
        chk("load_ark", dp_state, PT_A ^ KEY_A);
        chk("load_key", dp_key,   KEY_A);
        for (int k = 1; k <= NUM_ROUNDS; k++) begin
            chk($sformatf("rnd%0d_cnt", k),   round_cnt, 128'(k));
            chk($sformatf("rnd%0d_rcon", k),  dp_rcon,   rcon_tbl[k-1]);
            chk($sformatf("rnd%0d_final", k), dp_final,  (k == NUM_ROUNDS) ? 1 : 0);
            chk($sformatf("rnd%0d_ov", k),    out_valid, 0);
            chk($sformatf("rnd%0d_rdy", k),   in_ready,  0);
            tick();
        end
        chk("a_out_valid", out_valid, 1);
        chk("a_ct",        ct,        CT_A);
        chk("a_done_cnt",  round_cnt, 128'(NUM_ROUNDS));
        chk("a_done_fin",  dp_final,  0);
        tick();
        chk("a_idle_ov",   out_valid, 0);
        chk("a_idle_rdy",  in_ready,  1);
        chk("a_idle_cnt",  round_cnt, 0);
        chk("a_idle_busy", busy,      0);
        chk("a_idle_hold", ct,        CT_A);

        // ---- backpressure ----
        out_ready = 1'b0;
        start_job(PT_B, KEY_B, 1'b0);
        wait_done("b_latency");
        for (int i = 0; i < 20; i++) begin
            chk("bp_ct",  ct,        CT_B);
            chk("bp_ov",  out_valid, 1);
            chk("bp_rdy", in_ready,  0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_rel_rdy", in_ready,  1);
        chk("bp_rel_ov",  out_valid, 0);
        chk("bp_rel_cnt", round_cnt, 0);

        // ---- in_valid held across a job; new vector presented mid-job ----
        start_job(PT_A, KEY_A, 1'b1);
        pt  = PT_B;
        key = KEY_B;
        wait_done("hold_latency");
        chk("hold_ct_a",  ct,       CT_A);
        chk("hold_rdy_d", in_ready, 0);
        tick();
        chk("hold_idle_rdy", in_ready,  1);
        chk("hold_idle_cnt", round_cnt, 0);
        tick();
        in_valid = 1'b0;
        chk("hold_acc_cnt",  round_cnt, 1);
        chk("hold_acc_busy", busy,      1);
        wait_done("hold_b_latency");
        chk("hold_ct_b", ct, CT_B);
        tick();

        // ---- asynchronous reset mid-job ----
        start_job(PT_B, KEY_B, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("mid_cnt5", round_cnt, 5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ov",    out_valid, 0);
        chk("arst_cnt",   round_cnt, 0);
        chk("arst_state", dp_state,  0);
        chk("arst_key",   dp_key,    0);
        chk("arst_rcon",  dp_rcon,   8'h01);
        chk("arst_busy",  busy,      0);
        chk("arst_rdy",   in_ready,  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        chk("arst_no_ov", 128'(ov_seen), 0);
        start_job(PT_A, KEY_A, 1'b0);
        wait_done("arst_fresh_lat");
        chk("arst_fresh_ct", ct, CT_A);
        tick();

`ifdef AES_CTRL_ABORT_EN
        // ---- abort during ROUND ----
        out_ready = 1'b0;
        start_job(PT_B, KEY_B, 1'b0);
        tick();
        tick();
        chk("ab_cnt3", round_cnt, 3);
        @(negedge clk);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_cnt",   round_cnt, 0);
        chk("ab_state", dp_state,  0);
        chk("ab_key",   dp_key,    0);
        chk("ab_rcon",  dp_rcon,   8'h01);
        chk("ab_busy",  busy,      0);
        chk("ab_rdy",   in_ready,  1);

        // ---- abort together with out_ready in DONE ----
        start_job(PT_B, KEY_B, 1'b0);
        wait_done("ab_done_lat");
        chk("ab_done_ct", ct, CT_B);
        @(negedge clk);
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_hs_ov",    out_valid, 0);
        chk("ab_hs_state", dp_state,  0);
        chk("ab_hs_cnt",   round_cnt, 0);

        // ---- abort in IDLE does not block an accept ----
        @(negedge clk);
        abort    = 1'b1;
        in_valid = 1'b1;
        pt       = PT_A;
        key      = KEY_A;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("ab_idle_cnt",   round_cnt, 1);
        chk("ab_idle_state", dp_state,  PT_A ^ KEY_A);
        wait_done("ab_idle_lat");
        chk("ab_idle_ct", ct, CT_A);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
